// File: rtl/add_subtract_arbiter_if.sv
// add_subtract_arbiter_if
//   Bundles the request, response and add_subtract-side signals of the
//   add_subtract_arbiter. Signal suffixes (_i/_o) are from the arbiter's view.
//   Modports:
//     slave  - the arbiter itself
//     master - the clients plus the attached add_subtract unit
//   Signals:
//     req_valid_i/req_ready_o   per-requester request handshake (NREQ bits)
//     req_a_i/req_b_i           packed operands, requester n at [n*WIDTH +: WIDTH]
//     req_sub_i                 per-requester op select (1 = A-B)
//     rsp_valid_o/rsp_ready_i   per-requester response handshake
//     rsp_result_o/rsp_cout_o   registered result and carry/borrow
//     rsp_id_o                  index of the requester owning the response
//     alu_a_o/alu_b_o/alu_cin_o operands to add_subtract
//     alu_result_i/alu_cout_i   result from add_subtract
interface add_subtract_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_a_i;
  logic [NREQ*WIDTH-1:0] req_b_i;
  logic [NREQ-1:0]       req_sub_i;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [NREQ-1:0]       rsp_ready_i;
  logic [WIDTH-1:0]      rsp_result_o;
  logic                  rsp_cout_o;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      alu_a_o;
  logic [WIDTH-1:0]      alu_b_o;
  logic                  alu_cin_o;
  logic [WIDTH-1:0]      alu_result_i;
  logic                  alu_cout_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_sub_i, rsp_ready_i,
           alu_result_i, alu_cout_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_cout_o, rsp_id_o,
           alu_a_o, alu_b_o, alu_cin_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_sub_i, rsp_ready_i,
           alu_result_i, alu_cout_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_cout_o, rsp_id_o,
           alu_a_o, alu_b_o, alu_cin_o
  );
endinterface

// File: rtl/add_subtract_arbiter.sv
// add_subtract_arbiter
//   Shares one combinational add_subtract unit between NREQ requesters using
//   round-robin arbitration. The winner's operands are registered and driven
//   to the adder for one cycle; the registered result is returned to the
//   winner tagged with its index.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous reset, active-high
//     bus    - add_subtract_arbiter_if.slave (request/response/adder signals)
//     done_cnt_o[15:0] - completed-response counter, present only when
//                        ADDSUB_ARB_CNT_EN is defined
//
//   state | meaning
//   IDLE  | grant the round-robin winner and latch its operands
//   EXEC  | operands on the adder; capture result at end of cycle
//   RESP  | hold response for the owner until it accepts
module add_subtract_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  add_subtract_arbiter_if.slave bus
`ifdef ADDSUB_ARB_CNT_EN
  ,
  output logic [15:0]           done_cnt_o
`endif
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW:0]   NREQ_W = NREQ[IDW:0];
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic             rsp_hs;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;

  // Round-robin scan starting at ptr_q; the extra bit of cand absorbs ptr+i
  // before the modulo fold.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + i[IDW:0];
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_found && bus.req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign rsp_hs = (state_q == RESP) && bus.rsp_ready_i[id_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    result_d  = result_q;
    cout_d    = cout_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        // rst_i gate keeps ready low while reset holds the FSM in IDLE
        if (grant_found && !rst_i) begin
          req_ready = NREQ'(1) << grant_idx;
          a_d       = bus.req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
          b_d       = bus.req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
          sub_d     = bus.req_sub_i[grant_idx];
          id_d      = grant_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_result_i;
        cout_d   = bus.alu_cout_i;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid = NREQ'(1) << id_q;
        if (rsp_hs) begin
          ptr_d   = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Adder inputs come straight from the operand registers, so they hold the
  // last operation's values outside EXEC.
  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_cout_o   = cout_q;
  assign bus.rsp_id_o     = id_q;
  assign bus.alu_a_o      = a_q;
  assign bus.alu_b_o      = b_q;
  assign bus.alu_cin_o    = sub_q;

`ifdef ADDSUB_ARB_CNT_EN
  logic [15:0] done_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       done_cnt_q <= '0;
    else if (rsp_hs) done_cnt_q <= done_cnt_q + 16'd1;
  end

  assign done_cnt_o = done_cnt_q;
`endif
endmodule

// File: tb/tb_add_subtract_arbiter.sv
module tb_add_subtract_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_subtract_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef ADDSUB_ARB_CNT_EN
  logic [15:0] done_cnt;
`endif

  add_subtract_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ADDSUB_ARB_CNT_EN
    ,
    .done_cnt_o (done_cnt)
`endif
  );

  // Attached add_subtract unit: 33-bit arithmetic, bit 32 is carry/borrow.
  logic [WIDTH:0] alu_wide;
  always_comb begin
    alu_wide = bus.alu_cin_o ? ({1'b0, bus.alu_a_o} - {1'b0, bus.alu_b_o})
                             : ({1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o});
    bus.alu_result_i = alu_wide[WIDTH-1:0];
    bus.alu_cout_i   = alu_wide[WIDTH];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int ptr_m = 0;
  int cnt_m = 0;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic             op_s [NREQ];
  int grants [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int model_winner(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return 0;
  endfunction

  // Returns {cout, result}: carry on add, borrow (a < b) on subtract.
  function automatic logic [WIDTH:0] model_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(b);
    if (s) return {(la < lb) ? 1'b1 : 1'b0, WIDTH'(la - lb)};
    else   return {(la + lb) > 64'hFFFF_FFFF ? 1'b1 : 1'b0, WIDTH'(la + lb)};
  endfunction

  task automatic pack_operands();
    for (int n = 0; n < NREQ; n++) begin
      bus.req_a_i[n*WIDTH +: WIDTH] = op_a[n];
      bus.req_b_i[n*WIDTH +: WIDTH] = op_b[n];
      bus.req_sub_i[n]              = op_s[n];
    end
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic run_op(input logic [NREQ-1:0] mask, input int stall);
    int g;
    logic [WIDTH:0] exp;
    logic [NREQ-1:0] others;
    g = model_winner(mask);
    grants.push_back(g);
    exp = model_op(op_a[g], op_b[g], op_s[g]);
    pack_operands();
    bus.req_valid_i = mask;
    #1;
    check("grant", bus.req_ready_o, onehot(g));
    @(posedge clk); @(negedge clk);
    bus.req_valid_i[g] = 1'b0;
    others = bus.req_valid_i;
    #1;
    check("exec_ready_low", bus.req_ready_o, '0);
    check("exec_no_rsp", bus.rsp_valid_o, '0);
    check("exec_alu_a", bus.alu_a_o, op_a[g]);
    check("exec_alu_cin", bus.alu_cin_o, op_s[g]);
    @(posedge clk); @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) bus.rsp_ready_i = ($urandom_range(0, 1) == 1) ? '1 : onehot(g);
      else            bus.rsp_ready_i = ~onehot(g);
      #1;
      check("rsp_valid", bus.rsp_valid_o, onehot(g));
      check("rsp_result", bus.rsp_result_o, exp[WIDTH-1:0]);
      check("rsp_cout", bus.rsp_cout_o, exp[WIDTH]);
      check("rsp_id", bus.rsp_id_o, g);
      if (others != '0) check("resp_ready_low", bus.req_ready_o, '0);
      @(posedge clk); @(negedge clk);
    end
    bus.rsp_ready_i = '0;
    #1;
    check("rsp_dropped", bus.rsp_valid_o, '0);
    ptr_m = (g + 1) % NREQ;
    cnt_m++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = '1;
    bus.rsp_ready_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_sub_i   = '0;
    for (int n = 0; n < NREQ; n++) begin
      op_a[n] = 32'h1000_0000 * (n + 1) + 32'h11;
      op_b[n] = 32'h0000_0100 * (n + 3);
      op_s[n] = n[0];
    end
    pack_operands();

    // Reset state: all outputs zero, no ready while reset with all valid.
    @(negedge clk); #1;
    check("rst_ready", bus.req_ready_o, '0);
    check("rst_rsp_valid", bus.rsp_valid_o, '0);
    check("rst_result", bus.rsp_result_o, '0);
    check("rst_id", bus.rsp_id_o, '0);
    check("rst_alu_a", bus.alu_a_o, '0);
    check("rst_alu_b", bus.alu_b_o, '0);
    check("rst_alu_cin", bus.alu_cin_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // All four valid continuously, immediate response accept: 0,1,2,3,0.
    grants.delete();
    for (int k = 0; k < 5; k++) run_op(4'b1111, 0);
    for (int k = 0; k < 5; k++) check("rr_order", grants[k], k % NREQ);

    // req0: 1 + 1
    op_a[0] = 32'h0000_0001; op_b[0] = 32'h0000_0001; op_s[0] = 1'b0;
    run_op(4'b0001, 0);
    check("t1_result", bus.rsp_result_o, 32'h0000_0002);

    // req1: 0x0002F145 - 0x000F1206 borrows
    op_a[1] = 32'h0002_F145; op_b[1] = 32'h000F_1206; op_s[1] = 1'b1;
    run_op(4'b0010, 0);
    check("t2_result", bus.rsp_result_o, 32'hFFF3_DF3F);
    check("t2_cout", bus.rsp_cout_o, 1'b1);

    // req2: all-ones + 1 wraps with carry, response stalled 5 cycles
    // while req1 also waits.
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0001; op_s[2] = 1'b0;
    run_op(4'b0110, 5);
    check("t4_result", bus.rsp_result_o, 32'h0000_0000);
    check("t4_cout", bus.rsp_cout_o, 1'b1);

    // Reset during EXEC of a req3 op.
    op_a[3] = 32'hA5A5_0001; op_b[3] = 32'h0000_0FFF; op_s[3] = 1'b1;
    pack_operands();
    bus.req_valid_i = 4'b1000;
    #1;
    check("t5_grant", bus.req_ready_o, 4'b1000);
    @(posedge clk); @(negedge clk);
    bus.req_valid_i = '1;
    rst = 1'b1;
    #1;
    check("t5_rsp_valid", bus.rsp_valid_o, '0);
    check("t5_ready", bus.req_ready_o, '0);
    check("t5_alu_a", bus.alu_a_o, '0);
    check("t5_alu_cin", bus.alu_cin_o, 1'b0);
    check("t5_id", bus.rsp_id_o, '0);
    @(posedge clk); @(negedge clk);
    check("t5_no_rsp", bus.rsp_valid_o, '0);
    rst = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
    grants.delete();
    run_op(4'b1111, 0);
    check("t5_next_grant", grants[0], 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 30; k++) begin
      for (int n = 0; n < NREQ; n++) begin
        op_a[n] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
        op_b[n] = ($urandom_range(0, 4) == 0) ? 32'h0000_0000 : $urandom;
        op_s[n] = $urandom_range(0, 1) == 1;
      end
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

`ifdef ADDSUB_ARB_CNT_EN
    check("done_cnt", done_cnt, 16'(cnt_m));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
